// File: rtl/snoop_bus_ctrl.sv
// snoop_bus_ctrl
// Two-CPU snooping coherence bus controller. It arbitrates the shared bus
// between CPU0 and CPU1 and broadcasts the winner's miss or invalidate to the
// peer core. It gathers the peer's snoop response and then steers the owner's
// fill source, which is either peer data or unified memory.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   read_miss/write_miss/invalidate [1:0]  per-CPU requests (bit i = CPU i)
//   BICO0, BICO1 [10:0]           block address from each CPU
//   cpu_search_found [1:0]        bit i: CPU i holds the snooped block
//   send_other_proc_data0/1 [15:0] data each CPU offers to its peer
//   grant [1:0]                   bus ownership (never both set)
//   cpu_search [1:0]              snoop strobe to the peer of the owner
//   BOCI [12:0]                   broadcast word {op, addr}
//   cpu_datasel0/1 [1:0]          fill source: 00 none, 01 peer, 10 memory
//   invalidate_from_other_cpu [1:0] invalidate strobe to the peer
//   other_proc_data0/1 [15:0]     peer data delivered to each CPU
//   bus_busy                      high whenever a transaction is in flight
module snoop_bus_ctrl #(
    parameter int unsigned SNOOP_WAIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  read_miss,
    input  logic [1:0]  write_miss,
    input  logic [1:0]  invalidate,
    input  logic [10:0] BICO0,
    input  logic [10:0] BICO1,
    input  logic [1:0]  cpu_search_found,
    input  logic [15:0] send_other_proc_data0,
    input  logic [15:0] send_other_proc_data1,
    output logic [1:0]  grant,
    output logic [1:0]  cpu_search,
    output logic [12:0] BOCI,
    output logic [1:0]  cpu_datasel0,
    output logic [1:0]  cpu_datasel1,
    output logic [1:0]  invalidate_from_other_cpu,
    output logic [15:0] other_proc_data0,
    output logic [15:0] other_proc_data1,
    output logic        bus_busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SNOOP = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [1:0] OP_INV   = 2'b11;

    localparam logic [1:0] SEL_PEER = 2'b01;
    localparam logic [1:0] SEL_MEM  = 2'b10;

    logic [1:0]  state;
    logic        owner;
    logic        rr;
    logic [1:0]  op;
    logic [3:0]  count;
    logic        found;

    logic [1:0]  req;
    logic        peer;
    logic [1:0]  peer_mask;
    logic        winner;
    logic [1:0]  winner_op;
    logic [10:0] winner_addr;
    logic        found_next;
    logic [1:0]  fill_sel;
    logic        release_bus;

    assign req  = read_miss | write_miss | invalidate;
    assign peer = ~owner;
    assign peer_mask = owner ? 2'b01 : 2'b10;

    // Arbitration and op selection for the cycle spent in IDLE. A lone
    // requester wins outright; a tie goes to the round-robin pointer.
    always_comb begin
        winner = (req == 2'b11) ? rr : req[1];
        if (invalidate[winner]) begin
            winner_op = OP_INV;
        end else if (write_miss[winner]) begin
            winner_op = OP_WRITE;
        end else begin
            winner_op = OP_READ;
        end
        winner_addr = winner ? BICO1 : BICO0;
        found_next  = found | cpu_search_found[peer];
        fill_sel    = found_next ? SEL_PEER : SEL_MEM;
        // The owner dropping its request ends the transaction from either
        // SNOOP (an abort, no datasel) or HOLD (normal completion).
        release_bus = (state != IDLE) && !req[owner];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                     <= IDLE;
            owner                     <= 1'b0;
            rr                        <= 1'b0;
            op                        <= 2'b00;
            count                     <= 4'd0;
            found                     <= 1'b0;
            grant                     <= 2'b00;
            cpu_search                <= 2'b00;
            BOCI                      <= 13'd0;
            cpu_datasel0              <= 2'b00;
            cpu_datasel1              <= 2'b00;
            invalidate_from_other_cpu <= 2'b00;
            bus_busy                  <= 1'b0;
        end else if (release_bus) begin
            state                     <= IDLE;
            rr                        <= peer;
            count                     <= 4'd0;
            found                     <= 1'b0;
            grant                     <= 2'b00;
            cpu_search                <= 2'b00;
            BOCI                      <= 13'd0;
            cpu_datasel0              <= 2'b00;
            cpu_datasel1              <= 2'b00;
            invalidate_from_other_cpu <= 2'b00;
            bus_busy                  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state      <= SNOOP;
                        owner      <= winner;
                        op         <= winner_op;
                        found      <= 1'b0;
                        count      <= 4'(SNOOP_WAIT);
                        grant      <= winner ? 2'b10 : 2'b01;
                        cpu_search <= winner ? 2'b01 : 2'b10;
                        BOCI       <= {winner_op, winner_addr};
                        bus_busy   <= 1'b1;
                        // An invalidate strobes the peer during its one and
                        // only SNOOP cycle.
                        invalidate_from_other_cpu <= (winner_op == OP_INV) ?
                                                     (winner ? 2'b01 : 2'b10) : 2'b00;
                    end
                end
                SNOOP: begin
                    invalidate_from_other_cpu <= 2'b00;
                    if (op == OP_INV) begin
                        state      <= HOLD;
                        count      <= 4'd0;
                        cpu_search <= 2'b00;
                    end else begin
                        found <= found_next;
                        count <= count - 4'd1;
                        if (count == 4'd1) begin
                            state      <= HOLD;
                            cpu_search <= 2'b00;
                            if (owner) begin
                                cpu_datasel1 <= fill_sel;
                            end else begin
                                cpu_datasel0 <= fill_sel;
                            end
                            // A write miss must also kill the peer's copy once
                            // ownership is settled.
                            if (op == OP_WRITE) begin
                                invalidate_from_other_cpu <= peer_mask;
                            end
                        end
                    end
                end
                HOLD: begin
                    invalidate_from_other_cpu <= 2'b00;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Peer data is a combinational pass-through, gated so nothing leaks out
    // unless the owner was told to fill from its peer.
    assign other_proc_data0 = (state == HOLD && cpu_datasel0 == SEL_PEER) ?
                              send_other_proc_data1 : 16'd0;
    assign other_proc_data1 = (state == HOLD && cpu_datasel1 == SEL_PEER) ?
                              send_other_proc_data0 : 16'd0;

endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// tb_snoop_bus_ctrl
// Self-checking bench for snoop_bus_ctrl. Transactions are described at the
// bus-protocol level (who requests what, when the peer answers, how long the
// owner holds the bus) and the expected outputs for every cycle are derived
// from those rules. A few directed transactions come first, then random ones.
module tb_snoop_bus_ctrl;

    localparam int SW = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  read_miss;
    logic [1:0]  write_miss;
    logic [1:0]  invalidate;
    logic [10:0] BICO0;
    logic [10:0] BICO1;
    logic [1:0]  cpu_search_found;
    logic [15:0] send_other_proc_data0;
    logic [15:0] send_other_proc_data1;
    logic [1:0]  grant;
    logic [1:0]  cpu_search;
    logic [12:0] BOCI;
    logic [1:0]  cpu_datasel0;
    logic [1:0]  cpu_datasel1;
    logic [1:0]  invalidate_from_other_cpu;
    logic [15:0] other_proc_data0;
    logic [15:0] other_proc_data1;
    logic        bus_busy;

    int testCount = 0;
    int failCount = 0;

    // Transaction description and reference state.
    // ops[i] bits are {invalidate, write_miss, read_miss} for CPU i.
    bit          rrModel;
    logic [2:0]  ops [2];
    logic [10:0] addrs [2];
    logic [15:0] foundPattern;
    int          holdLen;
    int          abortAt;
    bit          resetInHold;
    logic [15:0] fixedData;

    snoop_bus_ctrl #(.SNOOP_WAIT(SW)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .read_miss                 (read_miss),
        .write_miss                (write_miss),
        .invalidate                (invalidate),
        .BICO0                     (BICO0),
        .BICO1                     (BICO1),
        .cpu_search_found          (cpu_search_found),
        .send_other_proc_data0     (send_other_proc_data0),
        .send_other_proc_data1     (send_other_proc_data1),
        .grant                     (grant),
        .cpu_search                (cpu_search),
        .BOCI                      (BOCI),
        .cpu_datasel0              (cpu_datasel0),
        .cpu_datasel1              (cpu_datasel1),
        .invalidate_from_other_cpu (invalidate_from_other_cpu),
        .other_proc_data0          (other_proc_data0),
        .other_proc_data1          (other_proc_data1),
        .bus_busy                  (bus_busy)
    );

    // Free-running clock, active edge is posedge.
    always #5 clk = ~clk;

    function automatic logic [1:0] oneHot(input int i);
        return (i == 0) ? 2'b01 : 2'b10;
    endfunction

    // Single comparison point: counts and reports.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Compares every output against one expected bus snapshot.
    task automatic checkBus(input string phase, input logic [1:0] expGrant,
                            input logic [1:0] expSearch, input bit checkBoci,
                            input logic [12:0] expBoci, input logic expBusy,
                            input logic [1:0] expInv, input logic [1:0] expSel0,
                            input logic [1:0] expSel1, input logic [15:0] expData0,
                            input logic [15:0] expData1);
        checkOutput({phase, ".grant"}, 32'(grant), 32'(expGrant));
        checkOutput({phase, ".cpu_search"}, 32'(cpu_search), 32'(expSearch));
        if (checkBoci) checkOutput({phase, ".BOCI"}, 32'(BOCI), 32'(expBoci));
        checkOutput({phase, ".bus_busy"}, 32'(bus_busy), 32'(expBusy));
        checkOutput({phase, ".inv_other"}, 32'(invalidate_from_other_cpu), 32'(expInv));
        checkOutput({phase, ".datasel0"}, 32'(cpu_datasel0), 32'(expSel0));
        checkOutput({phase, ".datasel1"}, 32'(cpu_datasel1), 32'(expSel1));
        checkOutput({phase, ".data0"}, 32'(other_proc_data0), 32'(expData0));
        checkOutput({phase, ".data1"}, 32'(other_proc_data1), 32'(expData1));
    endtask

    task automatic driveRequests();
        read_miss  = {ops[1][0], ops[0][0]};
        write_miss = {ops[1][1], ops[0][1]};
        invalidate = {ops[1][2], ops[0][2]};
        BICO0      = addrs[0];
        BICO1      = addrs[1];
    endtask

    // Runs one bus transaction. Entered and left on the negedge of an idle
    // cycle. A non-owner request stays asserted and carries over.
    task automatic applyStimulus();
        int         w;
        int         p;
        int         snoopLen;
        logic [1:0] reqv;
        logic [1:0] op;
        logic [1:0] sel;
        logic       found;
        logic [15:0] d;
        logic [15:0] expData;

        checkBus("idle", 2'b00, 2'b00, 1'b0, 13'd0, 1'b0, 2'b00, 2'b00, 2'b00, 16'd0, 16'd0);
        driveRequests();
        cpu_search_found = 2'($urandom);

        reqv = {|ops[1], |ops[0]};
        w = (reqv == 2'b11) ? int'(rrModel) : (reqv[1] ? 1 : 0);
        p = 1 - w;
        op = ops[w][2] ? 2'b11 : (ops[w][1] ? 2'b10 : 2'b01);
        snoopLen = (op == 2'b11) ? 1 : SW;
        found = 1'b0;

        for (int c = 1; c <= snoopLen; c++) begin
            @(negedge clk);
            checkBus($sformatf("snoop%0d", c), oneHot(w), oneHot(p), 1'b1,
                     {op, addrs[w]}, 1'b1,
                     (op == 2'b11 && c == 1) ? oneHot(p) : 2'b00,
                     2'b00, 2'b00, 16'd0, 16'd0);
            if (c == abortAt) begin
                ops[w] = 3'b000;
                driveRequests();
                rrModel = (p == 1);
                @(negedge clk);
                return;
            end
            cpu_search_found[p] = foundPattern[c-1];
            cpu_search_found[w] = 1'($urandom);
            found = found | foundPattern[c-1];
        end

        sel = (op == 2'b11) ? 2'b00 : (found ? 2'b01 : 2'b10);
        for (int h = 1; h <= holdLen; h++) begin
            @(negedge clk);
            d = (fixedData != 16'd0) ? fixedData : 16'($urandom);
            if (w == 0) begin
                send_other_proc_data1 = d;
                send_other_proc_data0 = 16'($urandom);
            end else begin
                send_other_proc_data0 = d;
                send_other_proc_data1 = 16'($urandom);
            end
            cpu_search_found = 2'($urandom);
            #1;
            expData = (sel == 2'b01) ? d : 16'd0;
            checkBus($sformatf("hold%0d", h), oneHot(w), 2'b00, 1'b1, {op, addrs[w]}, 1'b1,
                     (op == 2'b10 && h == 1) ? oneHot(p) : 2'b00,
                     (w == 0) ? sel : 2'b00, (w == 1) ? sel : 2'b00,
                     (w == 0) ? expData : 16'd0, (w == 1) ? expData : 16'd0);
            if (resetInHold) begin
                rst = 1'b1;
                #1;
                checkBus("async_reset", 2'b00, 2'b00, 1'b1, 13'd0, 1'b0, 2'b00,
                         2'b00, 2'b00, 16'd0, 16'd0);
                ops[0] = 3'b000;
                ops[1] = 3'b000;
                driveRequests();
                #1;
                rst = 1'b0;
                rrModel = 1'b0;
                @(negedge clk);
                return;
            end
        end
        ops[w] = 3'b000;
        driveRequests();
        rrModel = (p == 1);
        @(negedge clk);
    endtask

    task automatic setTxn(input logic [15:0] pattern, input int hold, input int abortCycle,
                          input bit doReset, input logic [15:0] data);
        foundPattern = pattern;
        holdLen      = hold;
        abortAt      = abortCycle;
        resetInHold  = doReset;
        fixedData    = data;
    endtask

    initial begin
        rst = 1'b1;
        ops[0] = 3'b000;
        ops[1] = 3'b000;
        addrs[0] = 11'd0;
        addrs[1] = 11'd0;
        rrModel = 1'b0;
        driveRequests();
        cpu_search_found = 2'b00;
        send_other_proc_data0 = 16'd0;
        send_other_proc_data1 = 16'd0;
        repeat (2) @(negedge clk);
        checkBus("reset", 2'b00, 2'b00, 1'b1, 13'd0, 1'b0, 2'b00, 2'b00, 2'b00, 16'd0, 16'd0);
        rst = 1'b0;
        @(negedge clk);

        // CPU0 read miss, peer answers in the second snoop cycle.
        ops[0] = 3'b001; addrs[0] = 11'h123;
        setTxn(16'h0002, 2, 0, 1'b0, 16'hBEEF);
        applyStimulus();

        // CPU1 write miss, peer does not hold the block.
        ops[1] = 3'b010; addrs[1] = 11'h7FF;
        setTxn(16'h0000, 2, 0, 1'b0, 16'h0000);
        applyStimulus();

        // Simultaneous requests: CPU0 first, CPU1 held off and served next.
        ops[0] = 3'b001; addrs[0] = 11'h055;
        ops[1] = 3'b001; addrs[1] = 11'h2AA;
        setTxn(16'h0001, 1, 0, 1'b0, 16'h0000);
        applyStimulus();
        setTxn(16'h0000, 1, 0, 1'b0, 16'h0000);
        applyStimulus();

        // CPU0 invalidate.
        ops[0] = 3'b100; addrs[0] = 11'h040;
        setTxn(16'h0003, 2, 0, 1'b0, 16'h0000);
        applyStimulus();

        // CPU0 abandons its read miss in the first snoop cycle.
        ops[0] = 3'b001; addrs[0] = 11'h3C3;
        setTxn(16'h0003, 1, 1, 1'b0, 16'h0000);
        applyStimulus();

        // Reset in the middle of HOLD, then a fresh request.
        ops[1] = 3'b010; addrs[1] = 11'h111;
        setTxn(16'h0001, 1, 0, 1'b1, 16'h0000);
        applyStimulus();
        ops[0] = 3'b001; addrs[0] = 11'h222;
        setTxn(16'h0002, 1, 0, 1'b0, 16'h0000);
        applyStimulus();

        // Random traffic with carried-over held requests.
        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < 2; i++) begin
                if (ops[i] == 3'b000 && $urandom_range(0, 1) == 1) begin
                    ops[i]   = 3'($urandom_range(1, 7));
                    addrs[i] = 11'($urandom);
                end
            end
            if (ops[0] == 3'b000 && ops[1] == 3'b000) begin
                ops[0]   = 3'($urandom_range(1, 7));
                addrs[0] = 11'($urandom);
            end
            setTxn(16'($urandom), $urandom_range(1, 3),
                   ($urandom_range(0, 5) == 0) ? $urandom_range(1, SW) : 0,
                   1'b0, 16'h0000);
            applyStimulus();
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
